// File: rtl/k8088_bus_arbiter_if.sv
// k8088 bus bundle: CPU pins, DMA requester handshake and the synchronous memory port.
// slave = arbiter side, master = the surrounding CPU / requester / memory.
interface k8088_bus_arbiter_if;
    logic [19:0] cpu_address;
    logic [7:0]  cpu_out;
    logic        cpu_we;
    logic [7:0]  cpu_in;
    logic        cpu_chipen;

    logic        dma_req;
    logic [19:0] dma_addr;
    logic        dma_we;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;

    logic [19:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;

    modport slave (
        input  cpu_address, cpu_out, cpu_we,
        output cpu_in, cpu_chipen,
        input  dma_req, dma_addr, dma_we, dma_wdata,
        output dma_ack, dma_rvalid, dma_rdata,
        output mem_address, mem_wdata, mem_we,
        input  mem_rdata
    );

    modport master (
        output cpu_address, cpu_out, cpu_we,
        input  cpu_in, cpu_chipen,
        output dma_req, dma_addr, dma_we, dma_wdata,
        input  dma_ack, dma_rvalid, dma_rdata,
        input  mem_address, mem_wdata, mem_we,
        output mem_rdata
    );
endinterface

// File: rtl/k8088_bus_arbiter.sv
// Shares one memory port between the k8088 CPU and a DMA requester, freezing the CPU via chipen.
// Latency: request -> first ack 1 cycle once the CPU has had CPU_MIN cycles; rvalid 1 cycle after a read ack.
// Backpressure: requester holds req/addr until dma_ack; the CPU is stalled (chipen=0) while DMA owns the port.
module k8088_bus_arbiter #(
    parameter int CPU_MIN   = 4,
    parameter int BURST_MAX = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    k8088_bus_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {S_CPU, S_DMA, S_RESTORE} state_t;

    state_t      state, state_nxt;
    logic [7:0]  run, run_nxt;
    logic [7:0]  burst, burst_nxt;
    logic        rvalid_q;

    logic        chipen;
    logic        ack;
    logic [19:0] address;
    logic [7:0]  wdata;
    logic        we;

    // run counts earlier S_CPU cycles, so +1 includes the current one; this
    // gives exactly CPU_MIN CPU cycles per gap and still at least one when CPU_MIN=0.
    logic [8:0]  run_inc;
    logic [8:0]  burst_inc;
    logic        run_ok;
    logic        burst_more;

    assign run_inc    = {1'b0, run} + 9'd1;
    assign burst_inc  = {1'b0, burst} + 9'd1;
    assign run_ok     = run_inc >= 9'(CPU_MIN);
    assign burst_more = burst_inc < 9'(BURST_MAX);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_CPU;
            run      <= 8'd0;
            burst    <= 8'd0;
            rvalid_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            run      <= run_nxt;
            burst    <= burst_nxt;
            rvalid_q <= ack && !bus.dma_we;
        end
    end

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        burst_nxt = burst;
        chipen    = 1'b0;
        ack       = 1'b0;
        address   = bus.cpu_address;
        wdata     = bus.cpu_out;
        we        = bus.cpu_we;
        case (state)
            S_CPU: begin
                chipen  = 1'b1;
                run_nxt = (run == 8'hFF) ? run : run + 8'd1;
                if (bus.dma_req && run_ok) begin
                    state_nxt = S_DMA;
                    burst_nxt = 8'd0;
                end
            end
            S_DMA: begin
                ack     = bus.dma_req;
                address = bus.dma_addr;
                wdata   = bus.dma_wdata;
                // the held CPU write must never reach memory here
                we      = bus.dma_req && bus.dma_we;
                if (ack) burst_nxt = burst + 8'd1;
                if (!(bus.dma_req && burst_more)) state_nxt = S_RESTORE;
            end
            S_RESTORE: begin
                state_nxt = S_CPU;
                run_nxt   = 8'd0;
            end
            default: begin
                state_nxt = S_CPU;
            end
        endcase
    end

    assign bus.cpu_chipen  = chipen;
    assign bus.dma_ack     = ack;
    assign bus.mem_address = address;
    assign bus.mem_wdata   = wdata;
    assign bus.mem_we      = we;
    assign bus.cpu_in      = bus.mem_rdata;
    assign bus.dma_rdata   = bus.mem_rdata;
    assign bus.dma_rvalid  = rvalid_q;
endmodule

// File: tb/tb_k8088_bus_arbiter.sv
// Bench for k8088_bus_arbiter: directed scenarios plus randomized traffic against a
// rule-level ownership model and a shadow memory.
module tb_k8088_bus_arbiter;
    localparam int CPU_MIN   = 4;
    localparam int BURST_MAX = 8;
    localparam int PERIOD    = CPU_MIN + BURST_MAX + 1;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #20 clock = ~clock;

    k8088_bus_arbiter_if bus();

    k8088_bus_arbiter #(.CPU_MIN(CPU_MIN), .BURST_MAX(BURST_MAX)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;

    // synchronous 1-cycle memory, read-before-write
    logic [7:0]  mem [bit [19:0]];
    logic [7:0]  mem_q = 8'h00;
    logic        pre_vld = 1'b0;
    logic [19:0] pre_addr = 20'h0;
    logic [7:0]  pre_dat = 8'h0;
    assign bus.mem_rdata = mem_q;

    always @(posedge clock) begin
        if (pre_vld) mem[pre_addr] = pre_dat;
        mem_q <= mem.exists(bus.mem_address) ? mem[bus.mem_address] : 8'h00;
        if (bus.mem_we) mem[bus.mem_address] = bus.mem_wdata;
    end

    function automatic logic [7:0] mem_rd(input logic [19:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    // reference model: who owns the port, from the arbitration rules
    logic [7:0]  shadow [bit [19:0]];
    int          m_run, m_burst;
    bit          m_grant, m_restore, m_rvalid, cpu_free, rd_ok;
    logic [7:0]  exp_rd;
    bit          exp_chipen, exp_ack;
    logic [19:0] exp_addr;
    logic [7:0]  exp_wdata;
    logic        exp_we;

    function automatic logic [7:0] sh_rd(input logic [19:0] a);
        return shadow.exists(a) ? shadow[a] : 8'h00;
    endfunction

    task automatic model_reset();
        m_run = 0; m_burst = 0; m_grant = 0; m_restore = 0;
        m_rvalid = 0; cpu_free = 1; rd_ok = 0;
    endtask

    task automatic model_eval();
        exp_chipen = !(m_grant || m_restore);
        exp_ack    = m_grant && bus.dma_req;
        if (m_grant) begin
            exp_addr  = bus.dma_addr;
            exp_wdata = bus.dma_wdata;
            exp_we    = bus.dma_req && bus.dma_we;
        end else begin
            exp_addr  = bus.cpu_address;
            exp_wdata = bus.cpu_out;
            exp_we    = bus.cpu_we;
        end
    endtask

    task automatic model_advance();
        exp_rd = sh_rd(exp_addr);
        rd_ok  = 1;
        if (exp_we) shadow[exp_addr] = exp_wdata;
        m_rvalid = exp_ack && !bus.dma_we;
        cpu_free = exp_chipen;
        if (m_restore) begin
            m_restore = 0;
            m_run     = 0;
        end else if (m_grant) begin
            if (exp_ack) m_burst++;
            if (!bus.dma_req || m_burst >= BURST_MAX) begin
                m_grant   = 0;
                m_restore = 1;
            end
        end else begin
            if (m_run < 255) m_run++;
            if (bus.dma_req && m_run >= CPU_MIN) begin
                m_grant = 1;
                m_burst = 0;
            end
        end
    endtask

    task automatic finish_cycle();
        model_advance();
        @(negedge clock);
    endtask

    task automatic run_cycle();
        #1;
        model_eval();
        finish_cycle();
    endtask

    task automatic drive_dma(input bit req, input bit we, input logic [19:0] a, input logic [7:0] d);
        bus.dma_req = req; bus.dma_we = we; bus.dma_addr = a; bus.dma_wdata = d;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        drive_dma(0, 0, 20'h0, 8'h0);
        bus.cpu_we = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        bus.cpu_address = 20'h0ABCD; bus.cpu_out = 8'h11; bus.cpu_we = 1'b0;
        drive_dma(1, 1, 20'h55555, 8'h22);
        #1;
        total++; if (bus.cpu_chipen !== 1'b1) begin bad++; $display("FAIL reset_chipen got=%b want=1", bus.cpu_chipen); end
        total++; if (bus.dma_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", bus.dma_ack); end
        total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", bus.dma_rvalid); end
        total++; if (bus.mem_address !== 20'h0ABCD) begin bad++; $display("FAIL reset_mem_addr got=%h want=0abcd", bus.mem_address); end
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we got=%b want=0", bus.mem_we); end
        @(negedge clock);
        apply_reset();
    endtask

    task automatic test_idle();
        drive_dma(0, 0, 20'h0, 8'h0);
        for (int c = 0; c < 1000; c++) begin
            if (cpu_free) begin
                bus.cpu_address = 20'($urandom_range(0, 15));
                bus.cpu_out     = 8'($urandom);
                bus.cpu_we      = ($urandom_range(0, 3) == 0);
            end
            #1;
            total++; if (bus.cpu_chipen !== 1'b1) begin bad++; $display("FAIL idle_chipen c=%0d got=%b want=1", c, bus.cpu_chipen); end
            total++; if (bus.mem_address !== bus.cpu_address) begin bad++; $display("FAIL idle_addr c=%0d got=%h want=%h", c, bus.mem_address, bus.cpu_address); end
            total++; if (bus.mem_we !== bus.cpu_we) begin bad++; $display("FAIL idle_we c=%0d got=%b want=%b", c, bus.mem_we, bus.cpu_we); end
            model_eval();
            finish_cycle();
        end
        bus.cpu_we = 1'b0;
    endtask

    task automatic test_continuous();
        bit want_chipen, want_ack;
        int p;
        apply_reset();
        bus.cpu_we = 1'b0;
        for (int c = 0; c < 3 * PERIOD; c++) begin
            drive_dma(1, 0, 20'($urandom_range(0, 15)), 8'h0);
            #1;
            p = c % PERIOD;
            want_chipen = (p < CPU_MIN);
            want_ack    = (p >= CPU_MIN) && (p < CPU_MIN + BURST_MAX);
            total++; if (bus.cpu_chipen !== want_chipen) begin bad++; $display("FAIL cont_chipen c=%0d got=%b want=%b", c, bus.cpu_chipen, want_chipen); end
            total++; if (bus.dma_ack !== want_ack) begin bad++; $display("FAIL cont_ack c=%0d got=%b want=%b", c, bus.dma_ack, want_ack); end
            model_eval();
            finish_cycle();
        end
        drive_dma(0, 0, 20'h0, 8'h0);
        repeat (3) run_cycle();
    endtask

    task automatic test_single_read();
        bus.cpu_address = 20'h00001; bus.cpu_we = 1'b0;
        drive_dma(0, 0, 20'h0, 8'h0);
        pre_addr = 20'h12345; pre_dat = 8'hA5; pre_vld = 1'b1;
        shadow[20'h12345] = 8'hA5;
        run_cycle();
        pre_vld = 1'b0;
        repeat (CPU_MIN + 1) run_cycle();
        drive_dma(1, 0, 20'h12345, 8'h0);
        #1; model_eval();
        total++; if (bus.dma_ack !== 1'b0) begin bad++; $display("FAIL rd_req_cycle_ack got=%b want=0", bus.dma_ack); end
        finish_cycle();
        #1; model_eval();
        total++; if (bus.dma_ack !== 1'b1) begin bad++; $display("FAIL rd_ack got=%b want=1", bus.dma_ack); end
        total++; if (bus.cpu_chipen !== 1'b0) begin bad++; $display("FAIL rd_chipen got=%b want=0", bus.cpu_chipen); end
        finish_cycle();
        drive_dma(0, 0, 20'h0, 8'h0);
        #1; model_eval();
        total++; if (bus.dma_rvalid !== 1'b1) begin bad++; $display("FAIL rd_rvalid got=%b want=1", bus.dma_rvalid); end
        total++; if (bus.dma_rdata !== 8'hA5) begin bad++; $display("FAIL rd_rdata got=%h want=a5", bus.dma_rdata); end
        finish_cycle();
        #1; model_eval();
        total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL rd_rvalid_drop got=%b want=0", bus.dma_rvalid); end
        total++; if (bus.cpu_chipen !== 1'b0) begin bad++; $display("FAIL rd_restore_chipen got=%b want=0", bus.cpu_chipen); end
        finish_cycle();
        #1; model_eval();
        total++; if (bus.cpu_chipen !== 1'b1) begin bad++; $display("FAIL rd_resume_chipen got=%b want=1", bus.cpu_chipen); end
        finish_cycle();
    endtask

    task automatic test_dma_write_cpu_read();
        int n;
        bus.cpu_address = 20'h00100; bus.cpu_we = 1'b0;
        drive_dma(1, 1, 20'h00100, 8'h3C);
        n = 0;
        #1; model_eval();
        while (bus.dma_ack !== 1'b1 && n < 20) begin finish_cycle(); #1; model_eval(); n++; end
        total++; if (bus.dma_ack !== 1'b1) begin bad++; $display("FAIL wr_ack_timeout got=%b want=1", bus.dma_ack); end
        finish_cycle();
        drive_dma(0, 0, 20'h0, 8'h0);
        n = 0;
        #1; model_eval();
        while (bus.cpu_chipen !== 1'b1 && n < 20) begin finish_cycle(); #1; model_eval(); n++; end
        total++; if (bus.cpu_chipen !== 1'b1) begin bad++; $display("FAIL wr_chipen_timeout got=%b want=1", bus.cpu_chipen); end
        total++; if (bus.cpu_in !== 8'h3C) begin bad++; $display("FAIL wr_cpu_in got=%h want=3c", bus.cpu_in); end
        finish_cycle();
    endtask

    task automatic test_cpu_write_switch();
        bus.cpu_address = 20'h00010; bus.cpu_out = 8'h00; bus.cpu_we = 1'b0;
        drive_dma(0, 0, 20'h0, 8'h0);
        repeat (CPU_MIN + 1) run_cycle();
        drive_dma(1, 0, 20'h00300, 8'h0);
        #1; model_eval();
        total++; if (bus.cpu_chipen !== 1'b1) begin bad++; $display("FAIL sw_last_cpu_chipen got=%b want=1", bus.cpu_chipen); end
        finish_cycle();
        // the CPU executed the switch cycle, so its new write appears now and is held
        bus.cpu_address = 20'h00200; bus.cpu_out = 8'h77; bus.cpu_we = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1; model_eval();
            total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL sw_dma_mem_we k=%0d got=%b want=0", k, bus.mem_we); end
            finish_cycle();
        end
        drive_dma(0, 0, 20'h0, 8'h0);
        #1; model_eval();
        total++; if (bus.mem_we !== 1'b0) begin bad++; $display("FAIL sw_dma_idle_we got=%b want=0", bus.mem_we); end
        finish_cycle();
        #1; model_eval();
        total++; if (bus.mem_we !== 1'b1 || bus.mem_address !== 20'h00200) begin bad++; $display("FAIL sw_restore_write got_we=%b got_addr=%h want=1/00200", bus.mem_we, bus.mem_address); end
        total++; if (bus.cpu_chipen !== 1'b0) begin bad++; $display("FAIL sw_restore_chipen got=%b want=0", bus.cpu_chipen); end
        finish_cycle();
        #1; model_eval();
        total++; if (mem_rd(20'h00200) !== 8'h77) begin bad++; $display("FAIL sw_mem_commit got=%h want=77", mem_rd(20'h00200)); end
        total++; if (bus.cpu_chipen !== 1'b1) begin bad++; $display("FAIL sw_resume_chipen got=%b want=1", bus.cpu_chipen); end
        finish_cycle();
        bus.cpu_we = 1'b0;
        run_cycle();
    endtask

    task automatic test_reset_mid_burst();
        int acks, n;
        apply_reset();
        bus.cpu_we = 1'b0;
        acks = 0; n = 0;
        while (n < 40) begin
            drive_dma(1, 0, 20'($urandom_range(0, 15)), 8'h0);
            #1; model_eval();
            if (bus.dma_ack === 1'b1) acks++;
            if (acks == 3) break;
            finish_cycle();
            n++;
        end
        total++; if (acks != 3) begin bad++; $display("FAIL rst_third_ack_timeout got=%0d want=3", acks); end
        reset_n = 1'b0;
        #1;
        total++; if (bus.dma_ack !== 1'b0) begin bad++; $display("FAIL rst_async_ack got=%b want=0", bus.dma_ack); end
        total++; if (bus.cpu_chipen !== 1'b1) begin bad++; $display("FAIL rst_async_chipen got=%b want=1", bus.cpu_chipen); end
        drive_dma(0, 0, 20'h0, 8'h0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        #1; model_eval();
        total++; if (bus.dma_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b want=0", bus.dma_rvalid); end
        finish_cycle();
        #1; model_eval();
        total++; if (bus.dma_rvalid !== 1'b0 || bus.cpu_chipen !== 1'b1) begin bad++; $display("FAIL rst_after got_rvalid=%b got_chipen=%b want=0/1", bus.dma_rvalid, bus.cpu_chipen); end
        finish_cycle();
    endtask

    task automatic test_random();
        bit last_ack;
        apply_reset();
        last_ack = 0;
        for (int c = 0; c < 1500; c++) begin
            if (cpu_free) begin
                bus.cpu_address = 20'($urandom_range(0, 15));
                bus.cpu_out     = 8'($urandom);
                bus.cpu_we      = ($urandom_range(0, 3) == 0);
            end
            if (!bus.dma_req || last_ack) begin
                if ($urandom_range(0, 2) != 0)
                    drive_dma(1, 1'($urandom_range(0, 1)), 20'($urandom_range(0, 15)), 8'($urandom));
                else
                    drive_dma(0, 0, 20'h0, 8'h0);
            end
            #1; model_eval();
            total++; if (bus.cpu_chipen !== exp_chipen) begin bad++; $display("FAIL rnd_chipen c=%0d got=%b want=%b", c, bus.cpu_chipen, exp_chipen); end
            total++; if (bus.dma_ack !== exp_ack) begin bad++; $display("FAIL rnd_ack c=%0d got=%b want=%b", c, bus.dma_ack, exp_ack); end
            total++; if (bus.mem_address !== exp_addr || bus.mem_we !== exp_we || bus.mem_wdata !== exp_wdata) begin
                bad++; $display("FAIL rnd_mem c=%0d got=%h/%b/%h want=%h/%b/%h", c, bus.mem_address, bus.mem_we, bus.mem_wdata, exp_addr, exp_we, exp_wdata);
            end
            total++; if (bus.dma_rvalid !== m_rvalid) begin bad++; $display("FAIL rnd_rvalid c=%0d got=%b want=%b", c, bus.dma_rvalid, m_rvalid); end
            if (rd_ok) begin
                total++; if (bus.cpu_in !== exp_rd || bus.dma_rdata !== exp_rd) begin bad++; $display("FAIL rnd_rdata c=%0d got=%h/%h want=%h", c, bus.cpu_in, bus.dma_rdata, exp_rd); end
            end
            last_ack = exp_ack;
            finish_cycle();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_continuous();
        test_single_read();
        test_dma_write_cpu_read();
        test_cpu_write_switch();
        test_reset_mid_burst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
